// File: rtl/rd_data_return.sv
// ============================================================================
// Module      : rd_data_return
// Description : Read-data return stage around the 8:1 bank-select mux:
//               request accept, registered select, capture FIFO, host return.
//               Optional macro RSP_PARITY_EN adds a per-entry data parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_data_return #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [SEL_W-1:0]              req_bank,
  input  logic [TAG_W-1:0]              req_tag,
  input  logic [(1<<SEL_W)-1:0]         refresh_busy,
  output logic [SEL_W-1:0]              mux_sel,
  input  logic [DATA_W-1:0]             mux_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_data,
  output logic [SEL_W-1:0]              rsp_bank,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef RSP_PARITY_EN
  ,
  output logic                          rsp_parity
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W+1)'(FIFO_DEPTH);

  logic               ready_en_q;
  logic               inflight_q, inflight_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   bank_q, bank_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [DATA_W-1:0]  mem_data [FIFO_DEPTH];
  logic [SEL_W-1:0]   mem_bank [FIFO_DEPTH];
  logic [TAG_W-1:0]   mem_tag  [FIFO_DEPTH];
`ifdef RSP_PARITY_EN
  logic               mem_par  [FIFO_DEPTH];
`endif

  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W:0]     w_occupancy;

  // Credit covers both buffered entries and the read still in the select stage.
  assign w_occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
  assign req_ready   = ready_en_q && (w_occupancy < DEPTH_OCC) && !refresh_busy[req_bank];
  assign w_accept    = req_valid && req_ready;
  assign w_push      = inflight_q;
  assign w_pop       = rsp_valid && rsp_ready;

  always_comb begin
    inflight_d = w_accept;
    sel_d      = sel_q;
    bank_d     = bank_q;
    tag_d      = tag_q;
    if (w_accept) begin
      sel_d  = req_bank;
      bank_d = req_bank;
      tag_d  = req_tag;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      inflight_q <= 1'b0;
      sel_q      <= '0;
      bank_q     <= '0;
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      inflight_q <= inflight_d;
      sel_q      <= sel_d;
      bank_q     <= bank_d;
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      mem_data[wr_ptr_q] <= mux_data;
      mem_bank[wr_ptr_q] <= bank_q;
      mem_tag[wr_ptr_q]  <= tag_q;
`ifdef RSP_PARITY_EN
      mem_par[wr_ptr_q]  <= ^mux_data;
`endif
    end
  end

  assign mux_sel    = sel_q;
  assign fifo_count = count_q;
  assign rsp_valid  = (count_q != '0);
  assign rsp_data   = rsp_valid ? mem_data[rd_ptr_q] : '0;
  assign rsp_bank   = rsp_valid ? mem_bank[rd_ptr_q] : '0;
  assign rsp_tag    = rsp_valid ? mem_tag[rd_ptr_q]  : '0;
`ifdef RSP_PARITY_EN
  assign rsp_parity = rsp_valid ? mem_par[rd_ptr_q]  : 1'b0;
`endif

endmodule

`default_nettype wire
